// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, decode opcode
// constants and the countdown width helper.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } ctrl_state_t;

  // Opcodes decode uses to raise halt_req / muldiv_start.
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDV = 7'b0000001;

  function automatic int cnt_width(input int md_cycles, input int dr_cycles);
    int m;
    m = (md_cycles > dr_cycles) ? md_cycles : dr_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_countdown.sv
// Loadable down-counter shared by the mul/div busy window and the halt drain.
module pipe_stall_ctrl_countdown #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencer: merges hazard stalls, redirects, mul/div occupancy
// and halt draining into stage enables. Optional STALL_PERF_EN adds a stall counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 6,
  parameter int DRAIN_CYCLES  = 3,
  parameter int CNT_WIDTH     = 32,
  parameter int CW            = cnt_width(MULDIV_CYCLES, DRAIN_CYCLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 need_nop,
  input  logic                 pc_stall,
  input  logic                 branch_taken,
  input  logic                 muldiv_start,
  input  logic                 halt_req,
  output logic                 pc_en,
  output logic                 pc_sel_tgt,
  output logic                 fd_en,
  output logic                 fd_flush,
  output logic                 de_bubble,
  output logic                 ex_hold,
  output logic                 muldiv_done,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [1:0]           state_dbg,
  output logic [CW-1:0]        count_dbg
);

  localparam logic [CW-1:0] MD_LOAD = CW'(MULDIV_CYCLES - 1);
  localparam logic [CW-1:0] DR_LOAD = CW'(DRAIN_CYCLES - 1);

  ctrl_state_t    state, state_nxt;
  logic           cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]  cnt_load_val, cnt_val;

  pipe_stall_ctrl_countdown #(.WIDTH(CW)) u_countdown (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Branch beats muldiv_start: a simultaneous mul/div op is on the wrong path.
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      ST_RUN: begin
        if (branch_taken) begin
          state_nxt = ST_RUN;
        end else if (muldiv_start) begin
          state_nxt    = ST_MD_BUSY;
          cnt_load     = 1'b1;
          cnt_load_val = MD_LOAD;
        end else if (halt_req) begin
          state_nxt    = ST_DRAIN;
          cnt_load     = 1'b1;
          cnt_load_val = DR_LOAD;
        end
      end
      ST_MD_BUSY: if (cnt_zero) state_nxt = ST_RUN;
      ST_DRAIN:   if (cnt_zero) state_nxt = ST_HALTED;
      default:    state_nxt = ST_HALTED;
    endcase
  end

  assign cnt_dec = (state == ST_MD_BUSY) || (state == ST_DRAIN);

  always_comb begin
    pc_en       = 1'b1;
    fd_en       = 1'b1;
    pc_sel_tgt  = 1'b0;
    fd_flush    = 1'b0;
    de_bubble   = 1'b0;
    ex_hold     = 1'b0;
    muldiv_done = 1'b0;
    halted      = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (branch_taken) begin
            pc_sel_tgt = 1'b1;
            fd_flush   = 1'b1;
            de_bubble  = 1'b1;
          end else if (muldiv_start) begin
            pc_en = 1'b1;
          end else if (halt_req) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
          end else begin
            pc_en     = ~pc_stall;
            fd_en     = ~need_nop;
            de_bubble = need_nop;
          end
        end
        ST_MD_BUSY: begin
          pc_en       = 1'b0;
          fd_en       = 1'b0;
          ex_hold     = ~cnt_zero;
          muldiv_done = cnt_zero;
        end
        ST_DRAIN: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_bubble = 1'b1;
        end
        default: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_bubble = 1'b1;
          halted    = 1'b1;
        end
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_en && state != ST_HALTED && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_count = reset ? '0 : stall_q;
`else
  assign stall_count = '0;
`endif

  assign state_dbg = state;
  assign count_dbg = cnt_val;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: cycle-number based reference model,
// directed scenarios with literal pins, then randomized traffic.
module tb_pipe_stall_ctrl;

  localparam int MD = 6;
  localparam int DR = 3;
`ifdef STALL_PERF_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif
  localparam int CW = $clog2(MD > DR ? MD : DR);
  localparam longint SAT = (64'd1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic need_nop = 0, pc_stall = 0, branch_taken = 0, muldiv_start = 0, halt_req = 0;
  logic pc_en, pc_sel_tgt, fd_en, fd_flush, de_bubble, ex_hold, muldiv_done, halted;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       state_dbg;
  logic [CW-1:0]    count_dbg;

  pipe_stall_ctrl #(.MULDIV_CYCLES(MD), .DRAIN_CYCLES(DR), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .reset(reset), .need_nop(need_nop), .pc_stall(pc_stall),
    .branch_taken(branch_taken), .muldiv_start(muldiv_start), .halt_req(halt_req),
    .pc_en(pc_en), .pc_sel_tgt(pc_sel_tgt), .fd_en(fd_en), .fd_flush(fd_flush),
    .de_bubble(de_bubble), .ex_hold(ex_hold), .muldiv_done(muldiv_done), .halted(halted),
    .stall_count(stall_count), .state_dbg(state_dbg), .count_dbg(count_dbg)
  );

  int total = 0;
  int bad   = 0;

  always @(posedge clk)
    if (!reset) assert (!(branch_taken && muldiv_start)) else $error("illegal branch+muldiv");

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic nn, ps, br, md, ht, rst);
    need_nop = nn; pc_stall = ps; branch_taken = br;
    muldiv_start = md; halt_req = ht; reset = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: expected output vectors queued by the model, popped by compare
  logic [8:0] exp_q[$];
  int     cyc = 0;
  int     md_done_cyc = -1, drain_end = -1, halt_cyc = -1;
  longint stall_m = 0;
  bit     model_valid = 0;

  always @(negedge clk) begin
    logic e_pc, e_fd, e_sel, e_fl, e_bub, e_hold, e_done, e_halt;
    int   e_st;
    logic [8:0] popped;
    e_pc = 1; e_fd = 1; e_sel = 0; e_fl = 0; e_bub = 0; e_hold = 0; e_done = 0; e_halt = 0;
    e_st = 0;
    if (reset) begin
      exp_q.push_back({e_pc, e_fd, e_sel, e_fl, e_bub, e_hold, e_done, e_halt, 1'b0});
      popped = exp_q.pop_front();
      check("reset_vec", {pc_en, fd_en, pc_sel_tgt, fd_flush, de_bubble, ex_hold, muldiv_done, halted, 1'b0}, popped);
      check("reset_stall_count", stall_count, 0);
      md_done_cyc = -1; drain_end = -1; halt_cyc = -1; stall_m = 0;
      model_valid = 1;
    end else if (model_valid) begin
      if (halt_cyc >= 0 && cyc >= halt_cyc) begin
        e_pc = 0; e_fd = 0; e_bub = 1; e_halt = 1; e_st = 3;
      end else if (cyc <= md_done_cyc) begin
        e_pc = 0; e_fd = 0; e_st = 1;
        if (cyc == md_done_cyc) e_done = 1; else e_hold = 1;
      end else if (cyc <= drain_end) begin
        e_pc = 0; e_fd = 0; e_bub = 1; e_st = 2;
      end else if (branch_taken) begin
        e_sel = 1; e_fl = 1; e_bub = 1;
      end else if (muldiv_start) begin
        md_done_cyc = cyc + MD;
      end else if (halt_req) begin
        e_pc = 0; e_fd = 0; e_bub = 1;
        drain_end = cyc + DR;
        halt_cyc  = drain_end + 1;
      end else begin
        e_pc = ~pc_stall; e_fd = ~need_nop; e_bub = need_nop;
      end
      exp_q.push_back({e_pc, e_fd, e_sel, e_fl, e_bub, e_hold, e_done, e_halt, 1'b0});
      popped = exp_q.pop_front();
      check("out_vec", {pc_en, fd_en, pc_sel_tgt, fd_flush, de_bubble, ex_hold, muldiv_done, halted, 1'b0}, popped);
      check("state_dbg", state_dbg, e_st);
`ifdef STALL_PERF_EN
      check("stall_count", stall_count, stall_m);
      if (!e_pc && !e_halt && stall_m < SAT) stall_m++;
`else
      check("stall_count_zero", stall_count, 0);
`endif
    end
    cyc++;
  end

  initial begin
    // reset phase
    drive(0, 0, 0, 0, 0, 1);
    check("rst_pc_en", pc_en, 1);
    check("rst_de_bubble", de_bubble, 0);
    repeat (3) tick();

    // 1: combined hazard stall for one cycle
    drive(1, 1, 0, 0, 0, 0);
    check("t1_pc_en", pc_en, 0);
    check("t1_fd_en", fd_en, 0);
    check("t1_bubble", de_bubble, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t1_pc_en_after", pc_en, 1);
    check("t1_fd_en_after", fd_en, 1);
    check("t1_bubble_after", de_bubble, 0);
    tick();

    // 2: mul/div occupancy
    drive(0, 0, 0, 1, 0, 0);
    check("t2_start_pc_en", pc_en, 1);
    tick();
    for (int i = 0; i < MD - 1; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 0, 0, $urandom_range(0, 1), 0);
      check("t2_ex_hold", ex_hold, 1);
      check("t2_no_done", muldiv_done, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("t2_done", muldiv_done, 1);
    check("t2_hold_low", ex_hold, 0);
    tick();
    check("t2_back_run", state_dbg, 0);
    check("t2_pc_en_run", pc_en, 1);

    // 3: branch overrides hazards and halt
    drive(1, 1, 1, 0, 1, 0);
    check("t3_pc_en", pc_en, 1);
    check("t3_sel", pc_sel_tgt, 1);
    check("t3_flush", fd_flush, 1);
    check("t3_bubble", de_bubble, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t3_stay_run", state_dbg, 0);
    tick();

    // 5: reset during third busy cycle
    drive(0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    drive(0, 0, 0, 0, 0, 1);
    check("t5_rst_hold", ex_hold, 0);
    check("t5_rst_pc_en", pc_en, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      check("t5_no_done", muldiv_done, 0);
      check("t5_run", state_dbg, 0);
      tick();
    end

`ifdef STALL_PERF_EN
    // 6: stall counter counts and saturates
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    repeat (5) tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t6_count5", stall_count, 5);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    repeat (20) tick();
    check("t6_saturated", stall_count, SAT);
`else
    drive(0, 1, 0, 0, 0, 0);
    repeat (5) tick();
    check("t6_count_off", stall_count, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 399);
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            (sel % 9 == 0), (sel % 9 == 1 && sel % 2 == 1), (sel == 7),
            (sel == 100));
      tick();
    end

    // 4: halt drain then sticky halted until reset
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("t4_bubble", de_bubble, 1);
    check("t4_pc_en", pc_en, 0);
    tick();
    for (int i = 0; i < DR; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      check("t4_drain", state_dbg, 2);
      check("t4_not_halted", halted, 0);
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0, $urandom_range(0, 1), 0);
      check("t4_halted", halted, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t4_halted_cleared", halted, 0);
    check("t4_pc_en_after", pc_en, 1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
